// File: rtl/bpsk_pkg.sv
// Shared types and elaboration-time helpers for the parametrised BPSK modulator:
// FSM state encoding, counter width helpers and the sine table generator.
package bpsk_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam real Pi = 3.14159265358979323846;

    // Width of the carrier phase counter (index into the sine table).
    function automatic int unsigned phase_cnt_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the carrier-period counter; at least one bit so a single
    // period per symbol still yields a legal vector.
    function automatic int unsigned cyc_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // Table entry k: round((2^(data_w-1)-1) * sin(2*pi*k/depth)), rounding half
    // away from zero. The amplitude stops one short of full scale so the
    // negated sample always fits.
    function automatic int sine_lut_entry(input int unsigned data_w,
                                          input int unsigned depth,
                                          input int unsigned k);
        real amp;
        real v;
        amp = real'((2 ** (data_w - 1)) - 1);
        v   = amp * $sin(2.0 * Pi * real'(k) / real'(depth));
        if (v >= 0.0) begin
            return int'($floor(v + 0.5));
        end else begin
            return -int'($floor(-v + 0.5));
        end
    endfunction

endpackage

// File: rtl/bpsk_sine_lut.sv
// One-period signed sine ROM, filled at elaboration. Purely combinational;
// the caller registers the selected sample.
module bpsk_sine_lut
    import bpsk_pkg::*;
#(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LUT_DEPTH = 8
) (
    input  logic        [phase_cnt_w(LUT_DEPTH)-1:0] addr_i,
    output logic signed [DATA_W-1:0]                 sample_o
);

    logic signed [DATA_W-1:0] rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam int Val = sine_lut_entry(DATA_W, LUT_DEPTH, k);
        assign rom[k] = DATA_W'(Val);
    end

    // Depth is a power of two, so every address selects a valid entry.
    assign sample_o = rom[addr_i];

endmodule

// File: rtl/bpsk_modulator_param.sv
// Parametrised BPSK modulator. Accepts one symbol bit per symbol over a
// valid/ready handshake and emits LUT_DEPTH*CYCLES_PER_SYM registered carrier
// samples per symbol, negated when the symbol sign is 1. Back-to-back symbols
// stream without gaps; a missing bit at a symbol boundary returns to idle and
// raises a one-cycle underrun pulse.
// Build option: define BPSK_DIFF_EN for differential (DBPSK) encoding, where
// each accepted 1 toggles the running carrier sign; otherwise the sign is the
// accepted bit itself.
module bpsk_modulator_param
    import bpsk_pkg::*;
#(
    parameter int unsigned DATA_W         = 12,
    parameter int unsigned LUT_DEPTH      = 8,
    parameter int unsigned CYCLES_PER_SYM = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     in_valid_i,
    input  logic                     in_bit_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output logic signed [DATA_W-1:0] out_o,
    output logic                     underrun_o
);

    localparam int unsigned PhaseW = phase_cnt_w(LUT_DEPTH);
    localparam int unsigned CycW   = cyc_cnt_w(CYCLES_PER_SYM);

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(LUT_DEPTH - 1);
    localparam logic [CycW-1:0]   CycLast   = CycW'(CYCLES_PER_SYM - 1);

    if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
        $error("bpsk_modulator_param: DATA_W must be within 4..16");
    end
    if (LUT_DEPTH < 4 || (LUT_DEPTH & (LUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bpsk_modulator_param: LUT_DEPTH must be a power of two >= 4");
    end
    if (CYCLES_PER_SYM < 1) begin : g_bad_cycles
        $error("bpsk_modulator_param: CYCLES_PER_SYM must be >= 1");
    end

    state_e                   state_q;
    logic [PhaseW-1:0]        phase_q;
    logic [CycW-1:0]          cyc_q;
    logic                     sign_q;
    logic signed [DATA_W-1:0] out_q;
    logic                     out_valid_q;
    logic                     underrun_q;

    logic                     last_sample;
    logic                     xfer;
    logic                     new_sign;
    logic                     sel_sign;
    logic [PhaseW-1:0]        lut_addr;
    logic signed [DATA_W-1:0] lut_sample;
    logic signed [DATA_W-1:0] sample_next;

    // Counters describe the sample currently on out_o, so the last sample of a
    // symbol is the cycle in which the next bit can be taken without a gap.
    assign last_sample = (phase_q == PhaseLast) && (cyc_q == CycLast);
    assign in_ready_o  = en_i && ((state_q == StIdle) || last_sample);
    assign xfer        = in_valid_i && in_ready_o;

`ifdef BPSK_DIFF_EN
    logic diff_q;

    assign new_sign = diff_q ^ in_bit_i;

    // Running differential state: toggles on every accepted 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            diff_q <= 1'b0;
        end else if (xfer) begin
            diff_q <= new_sign;
        end
    end
`else
    assign new_sign = in_bit_i;
`endif

    // Look up the sample that will be on out_o after the next edge.
    always_comb begin
        lut_addr    = xfer ? '0 : phase_q + PhaseW'(1);
        sel_sign    = xfer ? new_sign : sign_q;
        sample_next = sel_sign ? -lut_sample : lut_sample;
    end

    bpsk_sine_lut #(
        .DATA_W   (DATA_W),
        .LUT_DEPTH(LUT_DEPTH)
    ) u_sine_lut (
        .addr_i  (lut_addr),
        .sample_o(lut_sample)
    );

    // Symbol FSM with registered sample, valid and underrun outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            cyc_q       <= '0;
            sign_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else if (!en_i) begin
            // Frozen: everything holds except the single-cycle pulse.
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (xfer) begin
                state_q     <= StRun;
                phase_q     <= '0;
                cyc_q       <= '0;
                sign_q      <= new_sign;
                out_q       <= sample_next;
                out_valid_q <= 1'b1;
            end else if (state_q == StRun) begin
                if (last_sample) begin
                    state_q     <= StIdle;
                    phase_q     <= '0;
                    cyc_q       <= '0;
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                    underrun_q  <= 1'b1;
                end else begin
                    phase_q <= phase_q + PhaseW'(1);
                    if (phase_q == PhaseLast) begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                    out_q       <= sample_next;
                    out_valid_q <= 1'b1;
                end
            end else begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_bpsk_modulator_param.sv
// Directed bench for bpsk_modulator_param at DATA_W=12, LUT_DEPTH=8,
// CYCLES_PER_SYM=2. Expected samples come from a hand-written table; with
// BPSK_DIFF_EN defined the expected sign follows a differential model.
module tb_bpsk_modulator_param;

    localparam int DW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 in_valid;
    logic                 in_bit;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_s;
    logic                 underrun;

    int total = 0;
    int bad   = 0;

    int lut [8] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};

`ifdef BPSK_DIFF_EN
    bit m_diff = 1'b0;
`endif

    bpsk_modulator_param #(
        .DATA_W        (DW),
        .LUT_DEPTH     (8),
        .CYCLES_PER_SYM(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .in_valid_i (in_valid),
        .in_bit_i   (in_bit),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_o      (out_s),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected carrier sign for the next accepted bit.
    function automatic bit exp_sign(input bit b);
`ifdef BPSK_DIFF_EN
        m_diff = m_diff ^ b;
        return m_diff;
`else
        return b;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef BPSK_DIFF_EN
        m_diff = 1'b0;
`endif
    endtask

    // Checks all 16 samples of one symbol, one per cycle.
    task automatic sym_check(input bit neg, input string tag);
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("%s out s%0d", tag, s), out_s, neg ? -lut[s % 8] : lut[s % 8]);
            chk($sformatf("%s valid s%0d", tag, s), out_valid, 1);
            chk($sformatf("%s underrun s%0d", tag, s), underrun, 0);
            if (s == 7) chk($sformatf("%s ready mid", tag), in_ready, 0);
            if (s == 15) chk($sformatf("%s ready last", tag), in_ready, 1);
            tick();
        end
    endtask

    // First cycle after a symbol with no follow-on bit, then the idle cycle after.
    task automatic end_check(input string tag);
        chk({tag, " underrun pulse"}, underrun, 1);
        chk({tag, " valid drop"}, out_valid, 0);
        chk({tag, " out zero"}, out_s, 0);
        tick();
        chk({tag, " underrun clear"}, underrun, 0);
        chk({tag, " valid idle"}, out_valid, 0);
    endtask

    initial begin
        bit a;
        bit b;
        bit c;

        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;

        // Reset state
        #3;
        chk("rst out", out_s, 0);
        chk("rst valid", out_valid, 0);
        chk("rst underrun", underrun, 0);
        chk("rst ready en0", in_ready, 0);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        #1;
        chk("idle ready", in_ready, 1);
        tick();
        chk("idle valid", out_valid, 0);
        chk("idle underrun", underrun, 0);
        chk("idle out", out_s, 0);

        // Single bit 0
        in_valid = 1'b1;
        in_bit   = 1'b0;
        a        = exp_sign(1'b0);
        tick();
        in_valid = 1'b0;
        sym_check(a, "single");
        end_check("single end");

        // Back-to-back 0 then 1 with valid held
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b0;
        a        = exp_sign(1'b0);
        tick();
        in_bit = 1'b1;
        b      = exp_sign(1'b1);
        sym_check(a, "b2b sym0");
        in_valid = 1'b0;
        sym_check(b, "b2b sym1");
        end_check("b2b end");

        // Enable low for 3 cycles while out shows 2047
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b0;
        a        = exp_sign(1'b0);
        tick();
        in_valid = 1'b0;
        chk("stall s0", out_s, 0);
        tick();
        chk("stall s1", out_s, 1447);
        tick();
        chk("stall s2", out_s, 2047);
        en = 1'b0;
        #1;
        chk("stall ready en0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall hold out %0d", i), out_s, 2047);
            chk($sformatf("stall hold valid %0d", i), out_valid, 1);
            chk($sformatf("stall hold underrun %0d", i), underrun, 0);
        end
        en = 1'b1;
        for (int s = 3; s < 16; s++) begin
            tick();
            chk($sformatf("stall resume s%0d", s), out_s, lut[s % 8]);
        end
        chk("stall ready last", in_ready, 1);
        tick();
        end_check("stall end");

        // Asynchronous reset mid-symbol
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b0;
        a        = exp_sign(1'b0);
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) tick();
        chk("arst pre s5", out_s, -1447);
        #2;
        rst = 1'b1;
        #1;
        chk("arst out", out_s, 0);
        chk("arst valid", out_valid, 0);
        chk("arst underrun", underrun, 0);
        #1;
        rst = 1'b0;
`ifdef BPSK_DIFF_EN
        m_diff = 1'b0;
`endif
        #1;
        chk("arst ready after", in_ready, 1);
        tick();
        chk("arst idle valid", out_valid, 0);

        // Gap: no bit at the boundary, next bit 4 cycles later
        in_valid = 1'b1;
        in_bit   = 1'b1;
        a        = exp_sign(1'b1);
        tick();
        in_valid = 1'b0;
        sym_check(a, "gap sym0");
        end_check("gap end");
        tick();
        chk("gap3 valid", out_valid, 0);
        chk("gap3 underrun", underrun, 0);
        tick();
        chk("gap4 valid", out_valid, 0);
        chk("gap4 out", out_s, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        b        = exp_sign(1'b1);
        tick();
        in_valid = 1'b0;
        chk("gap restart valid", out_valid, 1);
        chk("gap restart s0", out_s, 0);
        for (int s = 1; s < 16; s++) begin
            tick();
            chk($sformatf("gap sym1 s%0d", s), out_s, b ? -lut[s % 8] : lut[s % 8]);
        end
        tick();
        end_check("gap sym1 end");

        // Bits 1,1,0 back-to-back
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        a        = exp_sign(1'b1);
        tick();
        b = exp_sign(1'b1);
        sym_check(a, "seq sym0");
        in_bit = 1'b0;
        c      = exp_sign(1'b0);
        sym_check(b, "seq sym1");
        in_valid = 1'b0;
        sym_check(c, "seq sym2");
        end_check("seq end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
